stack_machine: RTL and testbench



---
 rtl/stack_machine_pkg.sv | 50 +++++
 rtl/stack_machine_if.sv | 28 ++
 rtl/stack_lifo.sv | 52 +++++
 rtl/stack_machine.sv | 175 +++++++++++++++++
 tb/tb_stack_machine.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/stack_machine_pkg.sv
// rtl/stack_machine_pkg.sv - shared opcodes, class masks and FSM state for the stack machine
// Purpose: opcode constants, PUSH/EXT class decode helpers and the two-state
// fetch/execute enum shared by the core and its sub-modules.
// Ports: none (package).
package stack_machine_pkg;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_EXECUTE = 1'b1
  } state_t;

  // Immediate classes: 1iii_iiii is PUSH imm7, 01ii_iiii is EXT imm6.
  localparam logic [7:0] PUSH_MASK  = 8'h80;
  localparam logic [7:0] PUSH_MATCH = 8'h80;
  localparam logic [7:0] EXT_MASK   = 8'hC0;
  localparam logic [7:0] EXT_MATCH  = 8'h40;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_OR    = 8'h04;
  localparam logic [7:0] OP_XOR   = 8'h05;
  localparam logic [7:0] OP_NOT   = 8'h06;
  localparam logic [7:0] OP_SHL   = 8'h07;
  localparam logic [7:0] OP_SHR   = 8'h08;
  localparam logic [7:0] OP_DUP   = 8'h09;
  localparam logic [7:0] OP_DROP  = 8'h0A;
  localparam logic [7:0] OP_SWAP  = 8'h0B;
  localparam logic [7:0] OP_OVER  = 8'h0C;
  localparam logic [7:0] OP_EQ    = 8'h0D;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_STORE = 8'h11;
  localparam logic [7:0] OP_JMP   = 8'h12;
  localparam logic [7:0] OP_JZ    = 8'h13;
  localparam logic [7:0] OP_CALL  = 8'h14;
  localparam logic [7:0] OP_RET   = 8'h15;
  localparam logic [7:0] OP_HALT  = 8'h16;
  localparam logic [7:0] OP_TOR   = 8'h17;
  localparam logic [7:0] OP_FROMR = 8'h18;

  function automatic logic is_push(input logic [7:0] opcode);
    return (opcode & PUSH_MASK) == PUSH_MATCH;
  endfunction

  function automatic logic is_ext(input logic [7:0] opcode);
    return (opcode & EXT_MASK) == EXT_MATCH;
  endfunction

endpackage

// File: rtl/stack_machine_if.sv
// rtl/stack_machine_if.sv - external data/IO bus of the stack machine
// Purpose: groups the single-cycle bus and the executing opcode.
// Ports (master = core): addr, write, wr_data, op out; rd_data in.
interface stack_machine_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] rd_data;
  logic             write;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       op;

  modport master (
    output addr,
    output write,
    output wr_data,
    output op,
    input  rd_data
  );

  modport slave (
    input  addr,
    input  write,
    input  wr_data,
    input  op,
    output rd_data
  );
endinterface

// File: rtl/stack_lifo.sv
// rtl/stack_lifo.sv - wrapping LIFO used for the data and return stacks
// Purpose: circular stack with combinational top/second views.
// Ports: clock, reset (sync, active-high); push, pop[1:0] (0..2 entries),
//   swap, din in; top, second out.
// push with pop writes the result into the slot that becomes the new top, so
// push+pop=1 replaces T and push+pop=2 replaces N while dropping T.
module stack_lifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [1:0]       pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    second_idx;
  logic [PW-1:0]    wr_idx;

  // sp points at the next free slot; indices wrap modulo DEPTH.
  assign top_idx    = sp - PW'(1);
  assign second_idx = sp - PW'(2);
  assign wr_idx     = sp - PW'(pop);
  assign top        = mem[top_idx];
  assign second     = mem[second_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else begin
      sp <= sp - PW'(pop) + PW'(push);
    end
  end

  // Entries are not cleared by reset: underflow reads stale data.
  always_ff @(posedge clock) begin
    if (swap) begin
      mem[top_idx]    <= second;
      mem[second_idx] <= top;
    end else if (push) begin
      mem[wr_idx] <= din;
    end
  end
endmodule

// File: rtl/stack_machine.sv
// rtl/stack_machine.sv - 12-bit two-stack CPU core with internal program ROM
// Purpose: fetch/execute core, one instruction every two cycles.
// Ports: clock, reset (sync, active-high); bus (master): addr, write, wr_data,
//   op out, rd_data in (combinational, sampled in the same cycle).
module stack_machine
  import stack_machine_pkg::*;
#(
  parameter int    WIDTH    = 12,
  parameter int    PC_BITS  = 10,
  parameter int    DS_DEPTH = 16,
  parameter int    RS_DEPTH = 16,
  parameter string ROM_FILE = "program.hex"
) (
  input  logic clock,
  input  logic reset,
  stack_machine_if.master bus
);
  logic [7:0] rom [2**PC_BITS];

  state_t             state, state_next;
  logic [PC_BITS-1:0] pc, pc_next;
  logic [7:0]         ir, ir_next;

  logic             ds_push, ds_swap;
  logic [1:0]       ds_pop;
  logic [WIDTH-1:0] ds_din, t, n;
  logic             rs_push;
  logic [1:0]       rs_pop;
  logic [WIDTH-1:0] rs_din, r, rs_second_unused;
  logic             unused_r_high;

  logic [WIDTH-1:0] addr_c, wr_data_c;
  logic             write_c;

  // Return addresses are PC_BITS wide; the upper bits of R are never consumed.
  assign unused_r_high = ^r[WIDTH-1:PC_BITS];

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(DS_DEPTH)) u_ds (
    .clock  (clock),
    .reset  (reset),
    .push   (ds_push),
    .pop    (ds_pop),
    .swap   (ds_swap),
    .din    (ds_din),
    .top    (t),
    .second (n)
  );

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(RS_DEPTH)) u_rs (
    .clock  (clock),
    .reset  (reset),
    .push   (rs_push),
    .pop    (rs_pop),
    .swap   (1'b0),
    .din    (rs_din),
    .top    (r),
    .second (rs_second_unused)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    ds_push    = 1'b0;
    ds_pop     = 2'd0;
    ds_swap    = 1'b0;
    ds_din     = '0;
    rs_push    = 1'b0;
    rs_pop     = 2'd0;
    rs_din     = '0;
    addr_c     = '0;
    wr_data_c  = '0;
    write_c    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_next    = rom[pc];
        pc_next    = pc + 1'b1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_next = S_FETCH;
        if (is_push(ir)) begin
          ds_push = 1'b1;
          ds_din  = WIDTH'(ir[6:0]);
        end else if (is_ext(ir)) begin
          ds_push = 1'b1;
          ds_pop  = 2'd1;
          ds_din  = (t << 6) | WIDTH'(ir[5:0]);
        end else begin
          case (ir)
            OP_ADD:  begin ds_push = 1'b1; ds_pop = 2'd2; ds_din = n + t; end
            OP_SUB:  begin ds_push = 1'b1; ds_pop = 2'd2; ds_din = n - t; end
            OP_AND:  begin ds_push = 1'b1; ds_pop = 2'd2; ds_din = n & t; end
            OP_OR:   begin ds_push = 1'b1; ds_pop = 2'd2; ds_din = n | t; end
            OP_XOR:  begin ds_push = 1'b1; ds_pop = 2'd2; ds_din = n ^ t; end
            OP_NOT:  begin ds_push = 1'b1; ds_pop = 2'd1; ds_din = ~t; end
            OP_SHL:  begin ds_push = 1'b1; ds_pop = 2'd1; ds_din = t << 1; end
            OP_SHR:  begin ds_push = 1'b1; ds_pop = 2'd1; ds_din = t >> 1; end
            OP_DUP:  begin ds_push = 1'b1; ds_din = t; end
            OP_DROP: ds_pop = 2'd1;
            OP_SWAP: ds_swap = 1'b1;
            OP_OVER: begin ds_push = 1'b1; ds_din = n; end
            OP_EQ: begin
              ds_push = 1'b1;
              ds_pop  = 2'd2;
              ds_din  = (n == t) ? '1 : '0;
            end
            OP_LOAD: begin
              addr_c  = t;
              ds_push = 1'b1;
              ds_pop  = 2'd1;
              ds_din  = bus.rd_data;
            end
            OP_STORE: begin
              addr_c    = t;
              wr_data_c = n;
              write_c   = 1'b1;
              ds_pop    = 2'd2;
            end
            OP_JMP: begin
              pc_next = t[PC_BITS-1:0];
              ds_pop  = 2'd1;
            end
            OP_JZ: begin
              if (n == '0) pc_next = t[PC_BITS-1:0];
              ds_pop = 2'd2;
            end
            OP_CALL: begin
              // pc already points past the CALL byte.
              rs_push = 1'b1;
              rs_din  = WIDTH'(pc);
              pc_next = t[PC_BITS-1:0];
              ds_pop  = 2'd1;
            end
            OP_RET: begin
              pc_next = r[PC_BITS-1:0];
              rs_pop  = 2'd1;
            end
            OP_HALT: pc_next = pc - 1'b1;
            OP_TOR: begin
              rs_push = 1'b1;
              rs_din  = t;
              ds_pop  = 2'd1;
            end
            OP_FROMR: begin
              ds_push = 1'b1;
              ds_din  = r;
              rs_pop  = 2'd1;
            end
            default: ;
          endcase
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset masks the bus so a STORE interrupted by reset never strobes.
  assign bus.addr    = reset ? '0 : addr_c;
  assign bus.wr_data = reset ? '0 : wr_data_c;
  assign bus.write   = reset ? 1'b0 : write_c;
  assign bus.op      = ir;
endmodule

// File: tb/tb_stack_machine.sv
// tb/tb_stack_machine.sv - directed self-checking bench for stack_machine
module tb_stack_machine;
  typedef logic [7:0] prog_t [24];

  // 5+7 -> C00; LOAD C03 -> STORE C01; HALT
  localparam prog_t PROG_A = '{
    8'h85, 8'h87, 8'h01, 8'hB0, 8'h40, 8'h11, 8'hB0, 8'h43,
    8'h10, 8'hB0, 8'h41, 8'h11, 8'h16, 8'h16, 8'h16, 8'h16,
    8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16};
  // JZ taken to 7 (store 00A->C02), JZ not taken (store 00B->C01)
  localparam prog_t PROG_B = '{
    8'h80, 8'h87, 8'h13, 8'hD5, 8'hB0, 8'h40, 8'h11, 8'h8A,
    8'hB0, 8'h42, 8'h11, 8'h81, 8'h93, 8'h13, 8'h8B, 8'hB0,
    8'h41, 8'h11, 8'h16, 8'hE6, 8'hB0, 8'h40, 8'h11, 8'h16};
  // CALL 8: sub stores 0AA->C00, RET; then 00C->C01
  localparam prog_t PROG_C = '{
    8'h88, 8'h14, 8'h8C, 8'hB0, 8'h41, 8'h11, 8'h16, 8'h00,
    8'h82, 8'h6A, 8'hB0, 8'h40, 8'h11, 8'h15, 8'h16, 8'h16,
    8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16, 8'h16};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   idle_bad = 0;
  int   halt_bad = 0;
  logic [11:0] wr_addr_q[$];
  logic [11:0] wr_data_q[$];

  stack_machine_if #(.WIDTH(12)) bus ();

  stack_machine #(
    .WIDTH(12), .PC_BITS(10), .DS_DEPTH(16), .RS_DEPTH(16), .ROM_FILE("")
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.rd_data = (bus.addr == 12'hC03) ? 12'h001 : 12'h000;

  always @(negedge clock) begin
    if (bus.write === 1'b1) begin
      wr_addr_q.push_back(bus.addr);
      wr_data_q.push_back(bus.wr_data);
    end else if (!reset) begin
      if (bus.wr_data !== 12'h000) idle_bad++;
      if (bus.addr !== 12'h000 && bus.op !== 8'h10) idle_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input prog_t p);
    for (int i = 0; i < 1024; i++) dut.rom[i] = 8'h16;
    for (int i = 0; i < 24; i++) dut.rom[i] = p[i];
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic expect_two(input string tag, input logic [11:0] a0, input logic [11:0] d0,
                            input logic [11:0] a1, input logic [11:0] d1);
    check({tag, "_count"}, wr_addr_q.size(), 2);
    if (wr_addr_q.size() >= 1) begin
      check({tag, "_addr0"}, wr_addr_q[0], a0);
      check({tag, "_data0"}, wr_data_q[0], d0);
    end
    if (wr_addr_q.size() >= 2) begin
      check({tag, "_addr1"}, wr_addr_q[1], a1);
      check({tag, "_data1"}, wr_data_q[1], d1);
    end
  endtask

  task automatic restart(input prog_t p);
    @(negedge clock);
    reset = 1'b1;
    load_rom(p);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear_log();
    reset = 1'b0;
  endtask

  initial begin
    load_rom(PROG_A);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_op", bus.op, 8'h00);
    check("reset_write", bus.write, 1'b0);
    check("reset_addr", bus.addr, 12'h000);
    clear_log();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("first_fetch", bus.op, 8'h85);
    repeat (40) @(negedge clock);
    expect_two("prog_a", 12'hC00, 12'h00C, 12'hC01, 12'h001);

    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.op !== 8'h16 || bus.write !== 1'b0) halt_bad++;
    end
    check("halt_hold", halt_bad, 0);
    check("halt_no_write", wr_addr_q.size(), 2);

    // Reset during the EXECUTE of the first STORE (instruction 5)
    restart(PROG_A);
    repeat (11) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_store_op", bus.op, 8'h11);
    check("rst_store_write", bus.write, 1'b0);
    check("rst_store_addr", bus.addr, 12'h000);
    check("rst_store_log", wr_addr_q.size(), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_refetch", bus.op, 8'h85);
    repeat (40) @(negedge clock);
    expect_two("rst_rerun", 12'hC00, 12'h00C, 12'hC01, 12'h001);

    restart(PROG_B);
    repeat (60) @(negedge clock);
    expect_two("jz", 12'hC02, 12'h00A, 12'hC01, 12'h00B);
    check("jz_halt", bus.op, 8'h16);

    restart(PROG_C);
    repeat (60) @(negedge clock);
    expect_two("call", 12'hC00, 12'h0AA, 12'hC01, 12'h00C);
    check("call_rs_empty", dut.u_rs.sp, 4'd0);
    check("call_ds_empty", dut.u_ds.sp, 4'd0);
    check("call_halt", bus.op, 8'h16);

    check("idle_bus_zero", idle_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
